// File: rtl/es8psk_pkg.sv
// rtl/es8psk_pkg.sv - shared constants, FSM encoding and helpers for the 8PSK receive controller
//
// Contents:
//   FRAME_BITS   decoded frame width (bits)
//   FRAME_SYMS   8PSK symbols per frame (3 bits per symbol)
//   STAT_W       width of the saturating frame statistics counters
//   rx_state_t   controller FSM state encoding
//   sat_inc()    saturating increment for STAT_W counters
package es8psk_pkg;

    localparam int FRAME_BITS = 204;
    localparam int FRAME_SYMS = 68;
    localparam int STAT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_HOLDOFF = 2'd2
    } rx_state_t;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/frame_fifo2.sv
// rtl/frame_fifo2.sv - two-entry first-word-fall-through frame buffer
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset (empties the buffer)
//   wr_en        push request; ignored when full unless a pop happens in the same cycle
//   wr_data      entry to push
//   rd_en        pop request; ignored when empty
//   rd_data      head entry (zero when empty)
//   valid        head entry present
//   full, empty  occupancy flags
module frame_fifo2
    import es8psk_pkg::*;
#(
    parameter int WIDTH = FRAME_BITS + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic             full,
    output logic             empty
);

    // mem0 is always the head; mem1 holds the second entry when full.
    logic [WIDTH-1:0] mem0;
    logic [WIDTH-1:0] mem1;
    logic [1:0]       count;
    logic             do_pop;
    logic             do_push;
    logic             wr_hi;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign valid   = !empty;
    assign rd_data = valid ? mem0 : '0;

    assign do_pop  = rd_en && !empty;
    // A full buffer still takes a push when the head leaves in the same cycle.
    assign do_push = wr_en && (!full || do_pop);
    // Slot the new entry lands in after any same-cycle pop has shifted mem1 down.
    assign wr_hi   = full || ((count == 2'd1) && !do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem0  <= '0;
            mem1  <= '0;
            count <= 2'd0;
        end else begin
            if (do_pop) begin
                mem0 <= mem1;
            end
            if (do_push) begin
                if (wr_hi) begin
                    mem1 <= wr_data;
                end else begin
                    mem0 <= wr_data;
                end
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/es8psk_rx_ctrl.sv
// rtl/es8psk_rx_ctrl.sv - 8PSK frame receive controller: acquisition FSM, frame buffer, statistics
//
// Ports:
//   clk, reset          receiver clock, asynchronous active-high reset
//   enable              arms the receiver; low returns to IDLE and drops any frame in flight
//   ena_message         preamble-detect pulse; starts a frame from IDLE
//   ena_sym             demodulated-symbol strobe, counted while receiving
//   data_in, fail_in    decoded frame and decoder failure flag, qualified by ena_data
//   ena_data            decoder-done pulse; ends the frame
//   acq_gate            high while receiving
//   busy                high whenever not IDLE
//   out_data/out_fail   head-of-buffer frame and its fail flag
//   out_valid/out_ready head present / consumer accepts head
//   clear_stats         zeroes all statistics (wins over same-cycle increments)
//   stat_ok/fail/timeout/drop  saturating frame counters
module es8psk_rx_ctrl #(
    parameter int FRAME_SYMS  = es8psk_pkg::FRAME_SYMS,
    parameter int TIMEOUT_CYC = 1024,
    parameter int HOLDOFF_CYC = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              ena_message,
    input  logic                              ena_sym,
    input  logic [es8psk_pkg::FRAME_BITS-1:0] data_in,
    input  logic                              ena_data,
    input  logic                              fail_in,
    output logic                              acq_gate,
    output logic                              busy,
    output logic [es8psk_pkg::FRAME_BITS-1:0] out_data,
    output logic                              out_fail,
    output logic                              out_valid,
    input  logic                              out_ready,
    input  logic                              clear_stats,
    output logic [es8psk_pkg::STAT_W-1:0]     stat_ok,
    output logic [es8psk_pkg::STAT_W-1:0]     stat_fail,
    output logic [es8psk_pkg::STAT_W-1:0]     stat_timeout,
    output logic [es8psk_pkg::STAT_W-1:0]     stat_drop
);

    import es8psk_pkg::*;

    // Symbol counter saturates one past a full frame so overlong frames still read as bad.
    localparam int SYM_W = $clog2(FRAME_SYMS + 2);
    localparam int WD_W  = $clog2(TIMEOUT_CYC);
    localparam int HO_W  = $clog2(HOLDOFF_CYC);

    localparam logic [SYM_W-1:0] SYM_FULL = SYM_W'(FRAME_SYMS);
    localparam logic [SYM_W-1:0] SYM_SAT  = SYM_W'(FRAME_SYMS + 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [HO_W-1:0]  HO_LAST  = HO_W'(HOLDOFF_CYC - 1);

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [SYM_W-1:0] sym_cnt;
    logic [WD_W-1:0]  wd_cnt;
    logic [HO_W-1:0]  ho_cnt;

    logic             push_req;
    logic             push_fail;
    logic             timeout_hit;
    logic             push_accept;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FRAME_BITS:0] head;

    // Next state and frame-end events. enable low overrides everything, so a
    // frame finishing in the same cycle is discarded without being counted.
    always_comb begin
        state_nxt   = state;
        push_req    = 1'b0;
        push_fail   = 1'b0;
        timeout_hit = 1'b0;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ena_message) begin
                        state_nxt = ST_RECV;
                    end
                end
                ST_RECV: begin
                    // Decoder result takes priority over a coincident watchdog expiry.
                    if (ena_data) begin
                        push_req  = 1'b1;
                        push_fail = fail_in || (sym_cnt != SYM_FULL);
                        state_nxt = ST_HOLDOFF;
                    end else if (wd_cnt == WD_LAST) begin
                        timeout_hit = 1'b1;
                        state_nxt   = ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    if (ho_cnt == HO_LAST) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State register and per-state counters. Counters are held at zero in
    // IDLE, which also clears them on the IDLE->RECV edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            sym_cnt <= '0;
            wd_cnt  <= '0;
            ho_cnt  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_RECV: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    ho_cnt <= '0;
                    if (ena_sym && (sym_cnt != SYM_SAT)) begin
                        sym_cnt <= sym_cnt + 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    ho_cnt  <= ho_cnt + 1'b1;
                    sym_cnt <= '0;
                    wd_cnt  <= '0;
                end
                default: begin
                    sym_cnt <= '0;
                    wd_cnt  <= '0;
                    ho_cnt  <= '0;
                end
            endcase
        end
    end

    assign acq_gate = (state == ST_RECV);
    assign busy     = (state != ST_IDLE);

    frame_fifo2 #(
        .WIDTH(FRAME_BITS + 1)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (push_req),
        .wr_data({push_fail, data_in}),
        .rd_en  (out_ready),
        .rd_data(head),
        .valid  (out_valid),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign out_data = head[FRAME_BITS-1:0];
    assign out_fail = head[FRAME_BITS];

    // Mirrors the buffer's own acceptance rule: room, or head leaving this cycle.
    assign push_accept = push_req && (!fifo_full || (out_valid && out_ready));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_ok      <= '0;
            stat_fail    <= '0;
            stat_timeout <= '0;
            stat_drop    <= '0;
        end else if (clear_stats) begin
            stat_ok      <= '0;
            stat_fail    <= '0;
            stat_timeout <= '0;
            stat_drop    <= '0;
        end else begin
            if (push_accept && !push_fail) begin
                stat_ok <= sat_inc(stat_ok);
            end
            if (push_accept && push_fail) begin
                stat_fail <= sat_inc(stat_fail);
            end
            if (push_req && !push_accept) begin
                stat_drop <= sat_inc(stat_drop);
            end
            if (timeout_hit) begin
                stat_timeout <= sat_inc(stat_timeout);
            end
        end
    end

endmodule

// File: tb/tb_es8psk_rx_ctrl.sv
// tb/tb_es8psk_rx_ctrl.sv - self-checking bench for es8psk_rx_ctrl
module tb_es8psk_rx_ctrl;

    localparam int FS = 68;
    localparam int TO = 1024;
    localparam int HO = 32;
    localparam int FB = 204;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          ena_message;
    logic          ena_sym;
    logic [FB-1:0] data_in;
    logic          ena_data;
    logic          fail_in;
    logic          acq_gate;
    logic          busy;
    logic [FB-1:0] out_data;
    logic          out_fail;
    logic          out_valid;
    logic          out_ready;
    logic          clear_stats;
    logic [15:0]   stat_ok;
    logic [15:0]   stat_fail;
    logic [15:0]   stat_timeout;
    logic [15:0]   stat_drop;

    always #5 clk = ~clk;

    es8psk_rx_ctrl #(
        .FRAME_SYMS (FS),
        .TIMEOUT_CYC(TO),
        .HOLDOFF_CYC(HO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .ena_message (ena_message),
        .ena_sym     (ena_sym),
        .data_in     (data_in),
        .ena_data    (ena_data),
        .fail_in     (fail_in),
        .acq_gate    (acq_gate),
        .busy        (busy),
        .out_data    (out_data),
        .out_fail    (out_fail),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .clear_stats (clear_stats),
        .stat_ok     (stat_ok),
        .stat_fail   (stat_fail),
        .stat_timeout(stat_timeout),
        .stat_drop   (stat_drop)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [207:0] act, input logic [207:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_RECV, M_HOLD} mphase_t;
    mphase_t       m_phase;
    int            m_syms, m_age, m_hold;
    logic [FB:0]   m_q[$];
    int            m_ok, m_fail, m_to, m_drop;
    bit            mp_push, mp_fail, mp_to, mp_pop;

    function automatic int sat(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = M_IDLE;
            m_syms  = 0;
            m_age   = 0;
            m_hold  = 0;
            m_q.delete();
            m_ok    = 0;
            m_fail  = 0;
            m_to    = 0;
            m_drop  = 0;
        end else begin
            mp_push = 0;
            mp_fail = 0;
            mp_to   = 0;
            mp_pop  = (m_q.size() != 0) && out_ready;
            if (!enable) begin
                m_phase = M_IDLE;
            end else begin
                case (m_phase)
                    M_IDLE: begin
                        if (ena_message) begin
                            m_phase = M_RECV;
                            m_syms  = 0;
                            m_age   = 0;
                        end
                    end
                    M_RECV: begin
                        if (ena_data) begin
                            mp_push = 1;
                            mp_fail = fail_in || (m_syms != FS);
                            m_phase = M_HOLD;
                            m_hold  = 0;
                        end else if (m_age == TO - 1) begin
                            mp_to   = 1;
                            m_phase = M_HOLD;
                            m_hold  = 0;
                        end else begin
                            m_age++;
                            if (ena_sym && m_syms < FS + 1) m_syms++;
                        end
                    end
                    default: begin
                        m_hold++;
                        if (m_hold == HO) m_phase = M_IDLE;
                    end
                endcase
            end
            if (mp_pop) void'(m_q.pop_front());
            if (mp_push) begin
                if (m_q.size() < 2) begin
                    m_q.push_back({mp_fail, data_in});
                    if (mp_fail) m_fail = sat(m_fail);
                    else         m_ok   = sat(m_ok);
                end else begin
                    m_drop = sat(m_drop);
                end
            end
            if (mp_to) m_to = sat(m_to);
            if (clear_stats) begin
                m_ok   = 0;
                m_fail = 0;
                m_to   = 0;
                m_drop = 0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            check("cmp acq_gate", acq_gate, m_phase == M_RECV);
            check("cmp busy", busy, m_phase != M_IDLE);
            check("cmp out_valid", out_valid, m_q.size() != 0);
            if (m_q.size() != 0) begin
                check("cmp out_data", out_data, m_q[0][FB-1:0]);
                check("cmp out_fail", out_fail, m_q[0][FB]);
            end
            check("cmp stat_ok", stat_ok, 16'(m_ok));
            check("cmp stat_fail", stat_fail, 16'(m_fail));
            check("cmp stat_timeout", stat_timeout, 16'(m_to));
            check("cmp stat_drop", stat_drop, 16'(m_drop));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr();
        clear_stats = 1'b1;
        cyc(1);
        clear_stats = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        cyc(2);
        out_ready = 1'b0;
    endtask

    task automatic sym_burst(input int n);
        for (int i = 0; i < n; i++) begin
            ena_sym = 1'b1;
            cyc(1);
            ena_sym = 1'b0;
            cyc(1);
        end
    endtask

    // Returns in the first HOLDOFF cycle (one edge after the decoder-done pulse).
    task automatic send_frame(input int nsym, input bit fail, input logic [FB-1:0] d,
                              input bit rdy_pulse, input bit clr_pulse);
        ena_message = 1'b1;
        cyc(1);
        ena_message = 1'b0;
        cyc(1);
        sym_burst(nsym);
        data_in  = d;
        fail_in  = fail;
        ena_data = 1'b1;
        if (rdy_pulse) out_ready = 1'b1;
        if (clr_pulse) clear_stats = 1'b1;
        cyc(1);
        ena_data    = 1'b0;
        fail_in     = 1'b0;
        out_ready   = 1'b0;
        clear_stats = 1'b0;
    endtask

    logic [FB-1:0] d1, d2, d3;

    initial begin
        d1 = {51{4'hA}};
        d2 = {51{4'h5}};
        d3 = {17{12'h123}};
        reset = 1'b1;
        enable = 1'b1;
        ena_message = 1'b0;
        ena_sym = 1'b0;
        ena_data = 1'b0;
        fail_in = 1'b0;
        data_in = '0;
        out_ready = 1'b0;
        clear_stats = 1'b0;
        cyc(3);
        check("reset busy", busy, 1'b0);
        check("reset out_valid", out_valid, 1'b0);
        check("reset out_data", out_data, '0);
        check("reset stat_ok", stat_ok, 16'd0);
        reset = 1'b0;
        cyc(2);

        // Good frame: buffered next cycle, busy drops 32 cycles after HOLDOFF entry.
        send_frame(68, 1'b0, d1, 1'b0, 1'b0);
        check("good out_valid", out_valid, 1'b1);
        check("good out_fail", out_fail, 1'b0);
        check("good out_data", out_data, d1);
        check("good stat_ok", stat_ok, 16'd1);
        cyc(31);
        check("holdoff busy 31", busy, 1'b1);
        cyc(1);
        check("holdoff busy 32", busy, 1'b0);
        drain();
        check("drain out_valid", out_valid, 1'b0);

        // Short frame (67 symbols), decoder fail flag, overlong frame (70 symbols).
        clr();
        send_frame(67, 1'b0, d2, 1'b0, 1'b0);
        check("short out_fail", out_fail, 1'b1);
        check("short stat_fail", stat_fail, 16'd1);
        check("short stat_ok", stat_ok, 16'd0);
        cyc(HO);
        drain();
        send_frame(68, 1'b1, d2, 1'b0, 1'b0);
        cyc(HO);
        send_frame(70, 1'b0, d3, 1'b0, 1'b0);
        check("fail_in+long stat_fail", stat_fail, 16'd3);
        cyc(HO);
        drain();

        // Watchdog timeout.
        clr();
        ena_message = 1'b1;
        cyc(1);
        ena_message = 1'b0;
        cyc(TO - 1);
        check("timeout acq_gate last", acq_gate, 1'b1);
        cyc(1);
        check("timeout acq_gate fell", acq_gate, 1'b0);
        check("timeout stat_timeout", stat_timeout, 16'd1);
        check("timeout out_valid", out_valid, 1'b0);
        cyc(HO);

        // Decoder result on the watchdog's final cycle wins.
        clr();
        ena_message = 1'b1;
        cyc(1);
        ena_message = 1'b0;
        sym_burst(68);
        cyc(TO - 1 - 136);
        data_in  = d1;
        ena_data = 1'b1;
        cyc(1);
        ena_data = 1'b0;
        check("race stat_ok", stat_ok, 16'd1);
        check("race stat_timeout", stat_timeout, 16'd0);
        cyc(HO);
        drain();

        // Overflow: third frame dropped with no consumer.
        clr();
        send_frame(68, 1'b0, d1, 1'b0, 1'b0);
        cyc(HO);
        send_frame(68, 1'b0, d2, 1'b0, 1'b0);
        cyc(HO);
        send_frame(68, 1'b0, d3, 1'b0, 1'b0);
        check("ovf stat_ok", stat_ok, 16'd2);
        check("ovf stat_drop", stat_drop, 16'd1);
        check("ovf head", out_data, d1);
        cyc(HO);
        drain();

        // Same, but the consumer pops in the push cycle of the third frame.
        clr();
        send_frame(68, 1'b0, d1, 1'b0, 1'b0);
        cyc(HO);
        send_frame(68, 1'b0, d2, 1'b0, 1'b0);
        cyc(HO);
        send_frame(68, 1'b0, d3, 1'b1, 1'b0);
        check("popovf stat_drop", stat_drop, 16'd0);
        check("popovf stat_ok", stat_ok, 16'd3);
        check("popovf head", out_data, d2);
        cyc(HO);
        drain();

        // ena_message during HOLDOFF is ignored.
        clr();
        send_frame(68, 1'b0, d1, 1'b0, 1'b0);
        cyc(5);
        ena_message = 1'b1;
        cyc(1);
        ena_message = 1'b0;
        cyc(HO);
        check("hold msg busy", busy, 1'b0);
        check("hold msg stat_ok", stat_ok, 16'd1);

        // enable drop mid-frame discards it; stray ena_data in IDLE ignored.
        ena_message = 1'b1;
        cyc(1);
        ena_message = 1'b0;
        sym_burst(10);
        enable = 1'b0;
        cyc(1);
        check("disable busy", busy, 1'b0);
        check("disable acq_gate", acq_gate, 1'b0);
        ena_data = 1'b1;
        cyc(1);
        enable = 1'b1;
        cyc(1);
        ena_data = 1'b0;
        cyc(2);
        check("disable stat_ok", stat_ok, 16'd1);
        check("disable stat_fail", stat_fail, 16'd0);
        check("disable out_valid", out_valid, 1'b1);

        // Reset mid-frame with one buffered entry.
        ena_message = 1'b1;
        cyc(1);
        ena_message = 1'b0;
        sym_burst(5);
        #2;
        reset = 1'b1;
        #1;
        check("rst out_valid", out_valid, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst acq_gate", acq_gate, 1'b0);
        check("rst out_data", out_data, '0);
        check("rst stat_ok", stat_ok, 16'd0);
        cyc(2);
        reset = 1'b0;
        ena_message = 1'b1;
        cyc(1);
        ena_message = 1'b0;
        check("post-rst acq_gate", acq_gate, 1'b1);
        cyc(1);
        sym_burst(68);
        data_in     = d3;
        ena_data    = 1'b1;
        clear_stats = 1'b1;
        cyc(1);
        ena_data    = 1'b0;
        clear_stats = 1'b0;
        check("clr-win stat_ok", stat_ok, 16'd0);
        check("clr-win out_valid", out_valid, 1'b1);
        check("clr-win out_data", out_data, d3);
        cyc(HO + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
